// File: rtl/id_pkg.sv
// Shared types and decode helpers for the RSAASIP instruction-decode stage.
package id_pkg;

   typedef enum logic [2:0] {
      OP_NOP = 3'b000,
      OP_ADD = 3'b001,
      OP_SUB = 3'b010,
      OP_AND = 3'b011,
      OP_LI  = 3'b100,
      OP_LD  = 3'b101,
      OP_ST  = 3'b110,
      OP_JMP = 3'b111
   } opcode_e;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_RSV = 2'b11
   } alu_op_e;

   typedef struct packed {
      alu_op_e alu_op;
      logic    reg_we;
      logic    mem_rd;
      logic    mem_wr;
      logic    imm_sel;
      logic    jump;
   } ctrl_t;

   function automatic ctrl_t decode(input opcode_e op);
      ctrl_t c;
      c = '0;
      case (op)
         OP_ADD: begin c.alu_op = ALU_ADD; c.reg_we = 1'b1; end
         OP_SUB: begin c.alu_op = ALU_SUB; c.reg_we = 1'b1; end
         OP_AND: begin c.alu_op = ALU_AND; c.reg_we = 1'b1; end
         OP_LI:  begin c.imm_sel = 1'b1; c.reg_we = 1'b1; end
         OP_LD:  begin c.mem_rd = 1'b1; c.reg_we = 1'b1; c.imm_sel = 1'b1; end
         OP_ST:  begin c.mem_wr = 1'b1; c.imm_sel = 1'b1; end
         OP_JMP: c.jump = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

   function automatic logic uses_rs1(input opcode_e op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
             (op == OP_LD)  || (op == OP_ST);
   endfunction

   function automatic logic uses_rs2(input opcode_e op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
   endfunction

   // Stores read rd as the data source.
   function automatic logic uses_rd(input opcode_e op);
      return (op == OP_ST);
   endfunction

endpackage

// File: rtl/reg_file_bypass.sv
// NREGS x ARQ register file, 3 combinational read ports, 1 write port.
// A read of the register being written this cycle returns the write data.
module reg_file_bypass #(
   parameter int NREGS = 8,
   parameter int ARQ   = 16,
   parameter int REG_W = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [REG_W-1:0] waddr,
   input  logic [ARQ-1:0]   wdata,
   input  logic [REG_W-1:0] raddr_a,
   input  logic [REG_W-1:0] raddr_b,
   input  logic [REG_W-1:0] raddr_c,
   output logic [ARQ-1:0]   rdata_a,
   output logic [ARQ-1:0]   rdata_b,
   output logic [ARQ-1:0]   rdata_c
);

   logic [ARQ-1:0] mem_q [NREGS];
   logic [ARQ-1:0] mem_d [NREGS];

   // Next-state of the array: apply the write-back if enabled.
   always_comb begin
      mem_d = mem_q;
      if (we) mem_d[waddr] = wdata;
   end

   // Storage register, cleared on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) mem_q <= '{default: '0};
      else     mem_q <= mem_d;
   end

   // Read ports with write-through bypass.
   always_comb begin
      rdata_a = (we && waddr == raddr_a) ? wdata : mem_q[raddr_a];
      rdata_b = (we && waddr == raddr_b) ? wdata : mem_q[raddr_b];
      rdata_c = (we && waddr == raddr_c) ? wdata : mem_q[raddr_c];
   end

endmodule

// File: rtl/id_stage_pipe.sv
// Pipelined instruction-decode stage: decode, operand read with write-back
// bypass, ID/EX register with valid/ready, load-use bubble, flush, and a
// saturating count of bubble cycles.
module id_stage_pipe
   import id_pkg::*;
#(
   parameter int ARQ     = 16,
   parameter int NREGS   = 8,
   parameter int CNT_W   = 16,
   parameter int REG_W   = $clog2(NREGS),
   parameter int IMM_W   = ARQ - 3 - 2*REG_W,
   parameter int JADDR_W = ARQ - 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ARQ-1:0]     in_instr,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               flush,
   input  logic               wb_we,
   input  logic [REG_W-1:0]   wb_addr,
   input  logic [ARQ-1:0]     wb_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ARQ-1:0]     out_rs1_val,
   output logic [ARQ-1:0]     out_rs2_val,
   output logic [ARQ-1:0]     out_rd_val,
   output logic [ARQ-1:0]     out_imm,
   output logic [JADDR_W-1:0] out_jaddr,
   output logic [REG_W-1:0]   out_rd,
   output ctrl_t              out_ctrl,
   output logic [CNT_W-1:0]   stall_count
);

   opcode_e          op;
   logic [REG_W-1:0] f_rd, f_rs1, f_rs2;
   logic [ARQ-1:0]   imm_ext;
   logic [ARQ-1:0]   rs1_val, rs2_val, rd_val;
   logic             free, hazard;

   logic               valid_q, valid_d;
   logic               last_ld_valid_q, last_ld_valid_d;
   logic [REG_W-1:0]   last_ld_rd_q, last_ld_rd_d;
   logic [CNT_W-1:0]   stall_q, stall_d;
   logic [ARQ-1:0]     rs1_val_q, rs1_val_d, rs2_val_q, rs2_val_d, rd_val_q, rd_val_d;
   logic [ARQ-1:0]     imm_q, imm_d;
   logic [JADDR_W-1:0] jaddr_q, jaddr_d;
   logic [REG_W-1:0]   rd_q, rd_d;
   ctrl_t              ctrl_q, ctrl_d;

   // Instruction field extraction.
   always_comb begin
      op      = opcode_e'(in_instr[ARQ-1 -: 3]);
      f_rd    = in_instr[ARQ-4 -: REG_W];
      f_rs1   = in_instr[ARQ-4-REG_W -: REG_W];
      f_rs2   = in_instr[ARQ-4-2*REG_W -: REG_W];
      imm_ext = {{(ARQ-IMM_W){1'b0}}, in_instr[IMM_W-1:0]};
   end

   reg_file_bypass #(.NREGS(NREGS), .ARQ(ARQ), .REG_W(REG_W)) u_rf (
      .clk     (clk),
      .rst     (rst),
      .we      (wb_we),
      .waddr   (wb_addr),
      .wdata   (wb_data),
      .raddr_a (f_rs1),
      .raddr_b (f_rs2),
      .raddr_c (f_rd),
      .rdata_a (rs1_val),
      .rdata_b (rs2_val),
      .rdata_c (rd_val)
   );

   // Handshake and load-use hazard detection.
   always_comb begin
      free   = !valid_q || out_ready;
      hazard = in_valid && last_ld_valid_q &&
               ((uses_rs1(op) && f_rs1 == last_ld_rd_q) ||
                (uses_rs2(op) && f_rs2 == last_ld_rd_q) ||
                (uses_rd(op)  && f_rd  == last_ld_rd_q));
      in_ready = free && !hazard && !flush;
   end

   // ID/EX next-state, in priority order: flush, bubble, load, drain, hold.
   always_comb begin
      valid_d         = valid_q;
      last_ld_valid_d = last_ld_valid_q;
      last_ld_rd_d    = last_ld_rd_q;
      stall_d         = stall_q;
      rs1_val_d       = rs1_val_q;
      rs2_val_d       = rs2_val_q;
      rd_val_d        = rd_val_q;
      imm_d           = imm_q;
      jaddr_d         = jaddr_q;
      rd_d            = rd_q;
      ctrl_d          = ctrl_q;
      if (flush) begin
         valid_d         = 1'b0;
         last_ld_valid_d = 1'b0;
      end else if (free && hazard) begin
         valid_d         = 1'b0;
         last_ld_valid_d = 1'b0;
         if (stall_q != {CNT_W{1'b1}}) stall_d = stall_q + CNT_W'(1);
      end else if (in_valid && in_ready) begin
         valid_d         = 1'b1;
         last_ld_valid_d = (op == OP_LD);
         last_ld_rd_d    = f_rd;
         rs1_val_d       = rs1_val;
         rs2_val_d       = rs2_val;
         rd_val_d        = rd_val;
         imm_d           = imm_ext;
         jaddr_d         = in_instr[JADDR_W-1:0];
         rd_d            = f_rd;
         ctrl_d          = decode(op);
      end else if (free && !in_valid) begin
         valid_d         = 1'b0;
         last_ld_valid_d = 1'b0;
      end
   end

   // ID/EX pipeline register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q         <= 1'b0;
         last_ld_valid_q <= 1'b0;
         last_ld_rd_q    <= '0;
         stall_q         <= '0;
         rs1_val_q       <= '0;
         rs2_val_q       <= '0;
         rd_val_q        <= '0;
         imm_q           <= '0;
         jaddr_q         <= '0;
         rd_q            <= '0;
         ctrl_q          <= '0;
      end else begin
         valid_q         <= valid_d;
         last_ld_valid_q <= last_ld_valid_d;
         last_ld_rd_q    <= last_ld_rd_d;
         stall_q         <= stall_d;
         rs1_val_q       <= rs1_val_d;
         rs2_val_q       <= rs2_val_d;
         rd_val_q        <= rd_val_d;
         imm_q           <= imm_d;
         jaddr_q         <= jaddr_d;
         rd_q            <= rd_d;
         ctrl_q          <= ctrl_d;
      end
   end

   // Output drive.
   always_comb begin
      out_valid   = valid_q;
      out_rs1_val = rs1_val_q;
      out_rs2_val = rs2_val_q;
      out_rd_val  = rd_val_q;
      out_imm     = imm_q;
      out_jaddr   = jaddr_q;
      out_rd      = rd_q;
      out_ctrl    = ctrl_q;
      stall_count = stall_q;
   end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe (stall counter narrowed to 2 bits so
// saturation is reachable).
module tb_id_stage_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] in_instr;
   logic        in_valid;
   logic        in_ready;
   logic        flush;
   logic        wb_we;
   logic [2:0]  wb_addr;
   logic [15:0] wb_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_rs1_val, out_rs2_val, out_rd_val, out_imm;
   logic [12:0] out_jaddr;
   logic [2:0]  out_rd;
   id_pkg::ctrl_t out_ctrl;
   logic [1:0]  stall_count;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   id_stage_pipe #(.ARQ(16), .NREGS(8), .CNT_W(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_instr    (in_instr),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .flush       (flush),
      .wb_we       (wb_we),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_rs1_val (out_rs1_val),
      .out_rs2_val (out_rs2_val),
      .out_rd_val  (out_rd_val),
      .out_imm     (out_imm),
      .out_jaddr   (out_jaddr),
      .out_rd      (out_rd),
      .out_ctrl    (out_ctrl),
      .stall_count (stall_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_instr = '0; in_valid = 1'b0; flush = 1'b0;
      wb_we = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
      #12;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_stall", 32'(stall_count), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_ctrl", 32'(out_ctrl), 0);
      chk("rst_imm", 32'(out_imm), 0);
      rst = 1'b0;

      // LI r1,#5
      in_instr = 16'h8405; in_valid = 1'b1;
      tick();
      chk("li_valid", 32'(out_valid), 1);
      chk("li_imm", 32'(out_imm), 'h0005);
      chk("li_rd", 32'(out_rd), 1);
      chk("li_ctrl", 32'(out_ctrl), 'h12);

      // ADD r3,r2,r2 with same-cycle write-back to r2
      in_instr = 16'h2D20; wb_we = 1'b1; wb_addr = 3'd2; wb_data = 16'h1234;
      tick();
      wb_we = 1'b0;
      chk("byp_rs1", 32'(out_rs1_val), 'h1234);
      chk("byp_rs2", 32'(out_rs2_val), 'h1234);
      chk("byp_rd", 32'(out_rd), 3);
      chk("add_ctrl", 32'(out_ctrl), 'h10);

      // Same ADD, now from stored register file
      tick();
      chk("rf_rs1", 32'(out_rs1_val), 'h1234);

      // ST [r1], r2 : rd is the data source
      in_instr = 16'hC880;
      tick();
      chk("st_rd_val", 32'(out_rd_val), 'h1234);
      chk("st_rs1_val", 32'(out_rs1_val), 0);
      chk("st_ctrl", 32'(out_ctrl), 'h06);

      // SUB r3,r2,r2
      in_instr = 16'h4D20;
      tick();
      chk("sub_ctrl", 32'(out_ctrl), 'h30);
      chk("sub_rs2", 32'(out_rs2_val), 'h1234);

      // JMP 0x123
      in_instr = 16'hE123;
      tick();
      chk("jmp_ctrl", 32'(out_ctrl), 'h01);
      chk("jmp_addr", 32'(out_jaddr), 'h0123);

      // Load-use: LD r4,[r1] then ADD r5,r4,r0
      in_instr = 16'hB080;
      tick();
      chk("ld_ctrl", 32'(out_ctrl), 'h1A);
      chk("ld_rd", 32'(out_rd), 4);
      in_instr = 16'h3600;
      #1;
      chk("lu_in_ready", 32'(in_ready), 0);
      tick();
      chk("lu_bubble", 32'(out_valid), 0);
      chk("lu_stall", 32'(stall_count), 1);
      chk("lu_ready_after", 32'(in_ready), 1);
      tick();
      chk("lu_add_valid", 32'(out_valid), 1);
      chk("lu_add_rd", 32'(out_rd), 5);
      chk("lu_add_ctrl", 32'(out_ctrl), 'h10);

      // Backpressure: hold LI r6,#0x2A for 3 cycles
      in_instr = 16'h982A;
      tick();
      chk("bp_load_imm", 32'(out_imm), 'h2A);
      out_ready = 1'b0; in_instr = 16'h8403;
      #1;
      chk("bp_in_ready", 32'(in_ready), 0);
      repeat (3) begin
         tick();
         chk("bp_hold_valid", 32'(out_valid), 1);
         chk("bp_hold_imm", 32'(out_imm), 'h2A);
         chk("bp_hold_rd", 32'(out_rd), 6);
         chk("bp_hold_ready", 32'(in_ready), 0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_resume_ready", 32'(in_ready), 1);
      tick();
      chk("bp_next_imm", 32'(out_imm), 3);
      chk("bp_next_rd", 32'(out_rd), 1);
      in_valid = 1'b0;
      tick();
      chk("bp_drain", 32'(out_valid), 0);

      // Store-data hazard: LD r4 then ST with rd=r4
      in_instr = 16'hB080; in_valid = 1'b1;
      tick();
      in_instr = 16'hD000;
      #1;
      chk("sth_in_ready", 32'(in_ready), 0);
      tick();
      chk("sth_bubble", 32'(out_valid), 0);
      chk("sth_stall", 32'(stall_count), 2);
      tick();
      chk("sth_st_valid", 32'(out_valid), 1);
      chk("sth_st_ctrl", 32'(out_ctrl), 'h06);

      // Flush in the same cycle as a hazard
      in_instr = 16'hB080;
      tick();
      in_instr = 16'h3600; flush = 1'b1;
      #1;
      chk("fl_in_ready", 32'(in_ready), 0);
      tick();
      chk("fl_valid", 32'(out_valid), 0);
      chk("fl_stall", 32'(stall_count), 2);
      flush = 1'b0;
      #1;
      chk("fl_no_hazard", 32'(in_ready), 1);
      tick();
      chk("fl_add_valid", 32'(out_valid), 1);
      chk("fl_add_rd", 32'(out_rd), 5);
      chk("fl_stall_after", 32'(stall_count), 2);

      // Saturation: 5 load-use pairs on a 2-bit counter
      for (int i = 0; i < 5; i++) begin
         in_instr = 16'hB080;
         tick();
         in_instr = 16'h3600;
         tick();
         chk("sat_bubble", 32'(out_valid), 0);
         tick();
         chk("sat_count", 32'(stall_count), 3);
      end

      // Reset in the middle of a stall
      in_instr = 16'hB080;
      tick();
      in_instr = 16'h3600;
      #1;
      chk("mr_hazard", 32'(in_ready), 0);
      rst = 1'b1;
      #1;
      chk("mr_valid", 32'(out_valid), 0);
      chk("mr_stall", 32'(stall_count), 0);
      chk("mr_in_ready", 32'(in_ready), 1);
      #1;
      rst = 1'b0;
      in_instr = 16'h2D20;
      tick();
      chk("mr_rf_cleared", 32'(out_rs1_val), 0);
      chk("mr_add_valid", 32'(out_valid), 1);
      in_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
